// File: rtl/qif_neuron_array.sv
// qif_neuron_array: time-multiplexed array of quadratic integrate-and-fire
// neurons. One shared datapath (square, add, saturate) updates one neuron per
// cycle after a tick is accepted. Each neuron has a refractory counter. The
// membrane potentials can be read back combinationally.
// Optional build macro: QIF_LEAK_EN adds a leak term toward V_RESET. The leak
// is (V - V_RESET) >>> LEAK_SHIFT and is subtracted before saturation.
module qif_neuron_array #(
    parameter int NUM_NEURONS  = 4,
    parameter int WIDTH        = 8,
    parameter int V_RESET      = -20,
    parameter int V_TH         = 50,
    parameter int SQ_SHIFT     = 3,
    parameter int I_SHIFT      = 2,
    parameter int REFRAC_TICKS = 2,
    parameter int LEAK_SHIFT   = 4,
    localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,       // asynchronous, active-high
    input  logic                         tick_valid,
    output logic                         tick_ready,
    input  logic [NUM_NEURONS*WIDTH-1:0] i_syn,
    output logic                         spike_valid,
    output logic [NUM_NEURONS-1:0]       spike,
    input  logic [IW-1:0]                v_rd_idx,
    output logic [WIDTH-1:0]             v_rd_data
);

    localparam int SW = 2 * WIDTH + 2;
    localparam int RW = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;

    localparam logic signed [WIDTH-1:0] V_RST      = WIDTH'(V_RESET);
    localparam logic signed [WIDTH-1:0] V_THR      = WIDTH'(V_TH);
    localparam logic [RW-1:0]           REFR_LOAD  = RW'(REFRAC_TICKS);
    localparam logic [IW-1:0]           LAST_IDX   = IW'(NUM_NEURONS - 1);
    localparam logic signed [SW-1:0]    SAT_MAX    = SW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0]    SAT_MIN    = SW'(-(2 ** (WIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic signed [WIDTH-1:0]         v_q      [NUM_NEURONS];
    logic [RW-1:0]                   refrac_q [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]          spike_acc_q;
    logic [NUM_NEURONS-1:0]          spike_q;
    logic [NUM_NEURONS*WIDTH-1:0]    isyn_q;

    logic signed [WIDTH-1:0]         v_cur, i_cur, v_sh, i_sh, v_new;
    logic signed [2*WIDTH-1:0]       sq;
    logic signed [SW-1:0]            sum;
    logic [RW-1:0]                   refrac_cur, refrac_new;
    logic                            spk_new;
    logic [NUM_NEURONS-1:0]          spike_vec_d;
    logic                            accept;

    // Clamp the wide sum back into the signed membrane range.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] x);
        if (x > SAT_MAX)
            return SAT_MAX[WIDTH-1:0];
        else if (x < SAT_MIN)
            return SAT_MIN[WIDTH-1:0];
        else
            return x[WIDTH-1:0];
    endfunction

    assign accept = (state_q == IDLE) && tick_valid;

    // Shared neuron datapath: priority refractory > threshold > integrate.
    always_comb begin
        v_cur      = v_q[idx_q];
        refrac_cur = refrac_q[idx_q];
        i_cur      = isyn_q[idx_q*WIDTH +: WIDTH];
        v_sh       = v_cur >>> SQ_SHIFT;
        i_sh       = i_cur >>> I_SHIFT;
        sq         = (2*WIDTH)'(v_sh) * (2*WIDTH)'(v_sh);
        sum        = SW'(v_cur) + SW'(sq) + SW'(i_sh);
`ifdef QIF_LEAK_EN
        sum        = sum - ((SW'(v_cur) - SW'(V_RST)) >>> LEAK_SHIFT);
`endif
        v_new      = v_cur;
        refrac_new = refrac_cur;
        spk_new    = 1'b0;
        if (refrac_cur != '0) begin
            v_new      = V_RST;
            refrac_new = refrac_cur - RW'(1);
        end else if (v_cur >= V_THR) begin
            spk_new    = 1'b1;
            v_new      = V_RST;
            refrac_new = REFR_LOAD;
        end else begin
            v_new      = sat(sum);
        end
        spike_vec_d          = spike_acc_q;
        spike_vec_d[idx_q]   = spk_new;
    end

    // Next-state logic and handshake outputs of the tick FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tick_ready  = 1'b0;
        spike_valid = 1'b0;
        case (state_q)
            IDLE: begin
                tick_ready = 1'b1;
                if (tick_valid) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                if (idx_q == LAST_IDX)
                    state_d = DONE;
                else
                    idx_d = idx_q + IW'(1);
            end
            DONE: begin
                spike_valid = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and neuron state; reset aborts any step in progress.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            spike_acc_q <= '0;
            spike_q     <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_q[k]      <= V_RST;
                refrac_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == UPDATE) begin
                v_q[idx_q]      <= v_new;
                refrac_q[idx_q] <= refrac_new;
                spike_acc_q     <= spike_vec_d;
                if (idx_q == LAST_IDX)
                    spike_q <= spike_vec_d;
            end
        end
    end

    // Snapshot of the synaptic currents taken when a tick is accepted.
    always_ff @(posedge clk) begin
        if (accept)
            isyn_q <= i_syn;
    end

    // Membrane read-back; indices past the array read as zero.
    always_comb begin
        v_rd_data = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (v_rd_idx == IW'(k))
                v_rd_data = v_q[k];
        end
    end

    assign spike = spike_q;

endmodule

// File: tb/tb_qif_neuron_array.sv
// Directed bench for qif_neuron_array: a vector table on the default
// instance plus hand-written sequences. These cover read-back timing,
// saturation with SQ_SHIFT=2, back-to-back ticks and reset during a step.
module tb_qif_neuron_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        tv0 = 1'b0, tr0, sv0;
    logic [31:0] is0 = '0;
    logic [3:0]  sp0;
    logic [1:0]  ri0 = '0;
    logic [7:0]  rd0;

    logic        tv1 = 1'b0, tr1, sv1;
    logic [23:0] is1 = '0;
    logic [2:0]  sp1;
    logic [1:0]  ri1 = '0;
    logic [7:0]  rd1;

    qif_neuron_array u0 (
        .clk(clk), .rst_n(rst), .tick_valid(tv0), .tick_ready(tr0),
        .i_syn(is0), .spike_valid(sv0), .spike(sp0),
        .v_rd_idx(ri0), .v_rd_data(rd0)
    );

    qif_neuron_array #(.NUM_NEURONS(3), .SQ_SHIFT(2)) u1 (
        .clk(clk), .rst_n(rst), .tick_valid(tv1), .tick_ready(tr1),
        .i_syn(is1), .spike_valid(sv1), .spike(sp1),
        .v_rd_idx(ri1), .v_rd_data(rd1)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          do_rst;
        logic [31:0] isyn;
        logic [3:0]  spk;
        logic [31:0] v;      // expected V bytes {n3,n2,n1,n0}
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic rd_u0(input int k, output int val);
        ri0 = 2'(k);
        #1;
        val = int'($signed(rd0));
    endtask

    task automatic rd_u1(input int k, output int val);
        ri1 = 2'(k);
        #1;
        val = int'($signed(rd1));
    endtask

    // Accept one tick on the chosen instance and check spike_valid timing.
    task automatic run_tick(input int inst, input logic [31:0] isyn);
        int lat, first, cnt, c;
        logic rdy, sv;
        lat = (inst == 0) ? 5 : 4;
        c = 0;
        rdy = (inst == 0) ? tr0 : tr1;
        while (!rdy && c < 20) begin
            step();
            c++;
            rdy = (inst == 0) ? tr0 : tr1;
        end
        check("tick_ready_before_tick", int'(rdy), 1);
        if (inst == 0) begin
            is0 = isyn;
            tv0 = 1'b1;
        end else begin
            is1 = isyn[23:0];
            tv1 = 1'b1;
        end
        step();
        tv0 = 1'b0;
        tv1 = 1'b0;
        first = -1;
        cnt = 0;
        for (int k = 1; k <= lat + 1; k++) begin
            sv = (inst == 0) ? sv0 : sv1;
            if (sv) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k <= lat) step();
        end
        check("spike_valid_latency", first, lat);
        check("spike_valid_pulses", cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int val, sv_seen;

        tbl[0]  = '{1'b1, 32'h00000000, 4'h0, 32'hF5F5F5F5};
        tbl[1]  = '{1'b0, 32'h00000000, 4'h0, 32'hF9F9F9F9};
        tbl[2]  = '{1'b1, 32'h00000064, 4'h0, 32'hF5F5F50E};
        tbl[3]  = '{1'b0, 32'h00000064, 4'h0, 32'hF9F9F928};
        tbl[4]  = '{1'b0, 32'h00000064, 4'h0, 32'hFAFAFA5A};
        tbl[5]  = '{1'b0, 32'h00000064, 4'h1, 32'hFBFBFBEC};
        tbl[6]  = '{1'b0, 32'h00000064, 4'h0, 32'hFCFCFCEC};
        tbl[7]  = '{1'b0, 32'h00000064, 4'h0, 32'hFDFDFDEC};
        tbl[8]  = '{1'b0, 32'h00000064, 4'h0, 32'hFEFEFE0E};
        tbl[9]  = '{1'b1, 32'h80808080, 4'h0, 32'hD5D5D5D5};
        tbl[10] = '{1'b0, 32'h80808080, 4'h0, 32'hD9D9D9D9};
        tbl[11] = '{1'b1, 32'h28FC0700, 4'h0, 32'hFFF4F6F5};

        // Reset defaults
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rd_u0(k, val);
            check("reset_v", val, -20);
        end
        check("reset_tick_ready", int'(tr0), 1);
        check("reset_spike_valid", int'(sv0), 0);
        check("reset_spike", int'(sp0), 0);
        rd_u1(3, val);
        check("out_of_range_idx", val, 0);
        rd_u1(2, val);
        check("reset_v_u1", val, -20);

        // Vector table on the default instance
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_rst) do_reset();
            run_tick(0, tbl[i].isyn);
            check($sformatf("vec%0d_spike", i), int'(sp0), int'(tbl[i].spk));
            for (int k = 0; k < 4; k++) begin
                logic [31:0] ev;
                ev = tbl[i].v;
                rd_u0(k, val);
                check($sformatf("vec%0d_v%0d", i, k), val, int'($signed(ev[k*8 +: 8])));
            end
        end

        // Read-back follows each neuron's own update edge
        do_reset();
        ri0 = 2'd1;
        is0 = '0;
        tv0 = 1'b1;
        step();
        tv0 = 1'b0;
        check("rdback_c1", int'($signed(rd0)), -20);
        step();
        check("rdback_c2", int'($signed(rd0)), -20);
        step();
        check("rdback_c3", int'($signed(rd0)), -11);
        step();
        step();
        check("rdback_done", int'(sv0), 1);
        step();
        check("rdback_idle", int'(tr0), 1);

        // Saturation with SQ_SHIFT=2 on a 3-neuron instance
        do_reset();
        run_tick(1, 32'h00007F00);
        rd_u1(1, val); check("sat_t1_v1", val, 36);
        rd_u1(0, val); check("sat_t1_v0", val, 5);
        check("sat_t1_spike", int'(sp1), 0);
        run_tick(1, 32'h00007F00);
        rd_u1(1, val); check("sat_t2_v1", val, 127);
        rd_u1(2, val); check("sat_t2_v2", val, 6);
        run_tick(1, 32'h00007F00);
        check("sat_t3_spike", int'(sp1), 2);
        rd_u1(1, val); check("sat_t3_v1", val, -20);
        rd_u1(0, val); check("sat_t3_v0", val, 7);

        // tick_valid held high: accepts every 6 cycles, currents latched
        do_reset();
        is0 = '0;
        tv0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("cont_ready_k%0d", k), int'(tr0), (k % 6 == 0) ? 1 : 0);
            check($sformatf("cont_sv_k%0d", k), int'(sv0), (k % 6 == 5) ? 1 : 0);
            if (k == 1) is0 = 32'h64646464;
            if (k == 5) begin
                rd_u0(3, val);
                check("cont_latched_isyn", val, -11);
                is0 = '0;
            end
            if (k == 11) begin
                rd_u0(2, val);
                check("cont_second_step", val, -7);
                tv0 = 1'b0;
            end
            step();
        end
        check("cont_no_accept", int'(tr0), 1);
        step();
        check("cont_still_idle", int'(tr0), 1);

        // Reset in the middle of a step during the refractory period
        do_reset();
        for (int t = 0; t < 4; t++) run_tick(0, 32'h00000064);
        check("mid_pre_spike", int'(sp0), 1);
        is0 = 32'h00000064;
        tv0 = 1'b1;
        step();
        tv0 = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_spike_valid", int'(sv0), 0);
        check("mid_rst_spike", int'(sp0), 0);
        step();
        rst = 1'b0;
        sv_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (sv0) sv_seen++;
            step();
        end
        check("mid_no_spike_valid", sv_seen, 0);
        for (int k = 0; k < 4; k++) begin
            rd_u0(k, val);
            check("mid_v_reset", val, -20);
        end
        run_tick(0, 32'h00000064);
        rd_u0(0, val); check("mid_refrac_cleared_v0", val, 14);
        rd_u0(1, val); check("mid_after_v1", val, -11);
        check("mid_after_spike", int'(sp0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
